// File: rtl/dm_responder.sv
// Data-memory responder for the multi-cycle MIPS datapath: accepts a load/store,
// inserts WAIT_CYCLES wait states, then acks for one cycle. Optional byte enables via DM_BYTE_EN_EN.
module dm_responder #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
`ifdef DM_BYTE_EN_EN
    input  logic [3:0]  i_be,
`endif
    output logic        o_busy,
    output logic        o_ack,
    output logic [31:0] o_rdata,
    output logic        o_err
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam int         DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [3:0] CNT_INIT = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

    state_t                r_state, w_next;
    logic [3:0]            r_cnt, w_cnt_next;
    logic                  r_we;
    logic [31:0]           r_addr, r_wdata;
    logic [31:0]           r_rdata;
    logic                  r_err;
    logic [31:0]           r_mem [DEPTH];

    logic                  w_accept, w_enter_resp;
    logic                  w_acc_we, w_misaligned;
    logic [31:0]           w_acc_addr, w_acc_wdata, w_wmask;
    logic [DEPTH_LOG2-1:0] w_index;
    logic                  w_unused_addr;

`ifdef DM_BYTE_EN_EN
    logic [3:0]            r_be, w_acc_be;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // A new request is taken in IDLE and also in the single RESP cycle for back-to-back use.
    always_comb begin
        w_next       = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        w_enter_resp = 1'b0;
        o_busy       = 1'b0;
        o_ack        = 1'b0;
        case (r_state)
            S_IDLE, S_RESP: begin
                o_ack    = (r_state == S_RESP);
                w_accept = i_req;
                w_next   = S_IDLE;
                if (i_req) begin
                    if (WAIT_CYCLES > 0) begin
                        w_next     = S_WAIT;
                        w_cnt_next = CNT_INIT;
                    end else begin
                        w_next       = S_RESP;
                        w_enter_resp = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                o_busy = 1'b1;
                if (r_cnt == 4'd0) begin
                    w_next       = S_RESP;
                    w_enter_resp = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // With zero wait states the access happens on the accept edge, so use the live inputs.
    always_comb begin
        w_acc_we    = (r_state == S_WAIT) ? r_we    : i_we;
        w_acc_addr  = (r_state == S_WAIT) ? r_addr  : i_addr;
        w_acc_wdata = (r_state == S_WAIT) ? r_wdata : i_wdata;
        w_index     = w_acc_addr[DEPTH_LOG2+1:2];
        w_misaligned = (w_acc_addr[1:0] != 2'b00);
        w_wmask     = '1;
`ifdef DM_BYTE_EN_EN
        w_acc_be = (r_state == S_WAIT) ? r_be : i_be;
        if (w_acc_we) begin
            w_wmask = {{8{w_acc_be[3]}}, {8{w_acc_be[2]}}, {8{w_acc_be[1]}}, {8{w_acc_be[0]}}};
            case (w_acc_be)
                4'b0011, 4'b1100:                            w_misaligned = w_acc_addr[0];
                4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000: w_misaligned = 1'b0;
                default:                                     w_misaligned = (w_acc_addr[1:0] != 2'b00);
            endcase
        end
`endif
    end

    assign w_unused_addr = ^w_acc_addr[31:DEPTH_LOG2+2];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
`ifdef DM_BYTE_EN_EN
            r_be    <= '0;
`endif
        end else if (w_accept) begin
            r_we    <= i_we;
            r_addr  <= i_addr;
            r_wdata <= i_wdata;
`ifdef DM_BYTE_EN_EN
            r_be    <= i_be;
`endif
        end
    end

    // Memory contents survive reset; only the RESP entry edge may write.
    always_ff @(posedge i_clk) begin
        if (w_enter_resp && w_acc_we && !w_misaligned) begin
            r_mem[w_index] <= (r_mem[w_index] & ~w_wmask) | (w_acc_wdata & w_wmask);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_enter_resp) begin
            r_err   <= w_misaligned;
            r_rdata <= (!w_acc_we && !w_misaligned) ? r_mem[w_index] : 32'd0;
        end
    end

    assign o_rdata = o_ack ? r_rdata : 32'd0;
    assign o_err   = o_ack & r_err;

endmodule
